sv_uart_rx_word: RTL and testbench

Receive-side counterpart of the UART word transmitter. It recovers 8N1 bytes from the serial line and packs WORDS_NUM = DATA_WIDTH/8 consecutive bytes into one wide AXI-Stream word. The first byte received lands in the MSB byte, matching the transmitter's MSB-byte-first order. It sits between the pad-side irx input and the wide-word consumer, with error and timeout reporting for the host.

---
 rtl/sv_uart_rx_word.sv | 141 ++++++++++++++
 tb/tb_sv_uart_rx_word.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_uart_rx_word.sv
// 8N1 UART receiver that packs DATA_WIDTH/8 bytes (first byte in the MSB slot)
// into one AXI-Stream word, with frame-error, overrun and inter-byte timeout pulses.
module sv_uart_rx_word #(
  parameter int DATA_WIDTH   = 24,
  parameter int RX_PIPE      = 3,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  input  logic [15:0]           idivider,
  input  logic                  irx,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  oframe_err,
  output logic                  ooverrun,
  output logic                  otimeout,
  output logic                  obusy
);
  localparam int WORDS_NUM = DATA_WIDTH / 8;
  localparam int CW        = $clog2(WORDS_NUM + 1);
  localparam int TW        = 16 + $clog2(TIMEOUT_BITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic [RX_PIPE-1:0]    rx_pipe;
  logic                  rx_s, rx_d, armed;
  logic [15:0]           div, div_in, bcnt;
  logic [2:0]            bidx;
  logic [7:0]            shreg;
  logic [DATA_WIDTH-9:0] wbuf;
  logic [CW-1:0]         cnt;
  logic [TW-1:0]         tcnt, tlimit;
  logic                  start_det, tick, stop_ok, stop_bad, word_done, to_fire;

  assign rx_s   = rx_pipe[RX_PIPE-1];
  assign div_in = (idivider < 16'd4) ? 16'd4 : idivider;
  assign tick   = (bcnt == '0);
  assign tlimit = TW'(TIMEOUT_BITS) * {{(TW-16){1'b0}}, div};
  assign obusy  = (state != IDLE) || (cnt != '0);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE:  if (armed && rx_d && !rx_s) begin
               start_det = 1'b1;
               state_nxt = START;
             end
      START: if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (tick && bidx == 3'd7) state_nxt = STOP;
      STOP:  if (tick) begin
               state_nxt = IDLE;
               stop_ok   = rx_s;
               stop_bad  = !rx_s;
             end
      default: state_nxt = IDLE;
    endcase
  end

  assign word_done = stop_ok && (cnt == CW'(WORDS_NUM - 1));
  // A start edge in the same clock suppresses the timeout.
  assign to_fire   = (state == IDLE) && (cnt != '0) && !start_det && (tcnt == tlimit - 1'b1);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      rx_pipe       <= '1;
      rx_d          <= 1'b1;
      armed         <= 1'b1;
      div           <= '0;
      bcnt          <= '0;
      bidx          <= '0;
      shreg         <= '0;
      wbuf          <= '0;
      cnt           <= '0;
      tcnt          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      oframe_err    <= 1'b0;
      ooverrun      <= 1'b0;
      otimeout      <= 1'b0;
    end else begin
      rx_pipe    <= {rx_pipe[RX_PIPE-2:0], irx};
      rx_d       <= rx_s;
      oframe_err <= 1'b0;
      ooverrun   <= 1'b0;
      otimeout   <= 1'b0;

      // After a framing error, wait for an idle-high line before re-arming.
      if (stop_bad)  armed <= 1'b0;
      else if (rx_s) armed <= 1'b1;

      if (start_det) begin
        div  <= div_in;
        bcnt <= (div_in >> 1) - 16'd1;
        bidx <= '0;
      end else if (state != IDLE) begin
        bcnt <= tick ? div - 16'd1 : bcnt - 16'd1;
      end

      if (state == DATA && tick) begin
        shreg <= {rx_s, shreg[7:1]};
        bidx  <= bidx + 3'd1;
      end

      if (stop_ok) begin
        for (int i = 0; i < WORDS_NUM - 1; i++)
          if (cnt == CW'(i)) wbuf[DATA_WIDTH-9-8*i -: 8] <= shreg;
        cnt <= word_done ? '0 : cnt + 1'b1;
      end else if (stop_bad) begin
        cnt        <= '0;
        oframe_err <= 1'b1;
      end else if (to_fire) begin
        cnt      <= '0;
        otimeout <= 1'b1;
      end

      if (state != IDLE || cnt == '0 || start_det || to_fire) tcnt <= '0;
      else                                                   tcnt <= tcnt + 1'b1;

      if (word_done) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tdata  <= {wbuf, shreg};
          m_axis_tvalid <= 1'b1;
        end else begin
          ooverrun <= 1'b1;
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sv_uart_rx_word.sv
// Bench for sv_uart_rx_word: table of clean words, hand-written corner sequences,
// and random byte streams checked against a byte-queue reference model.
module tb_sv_uart_rx_word;
  localparam int DW = 24;
  localparam int RXP = 3;

  logic          iclk = 1'b0;
  logic          irst_n = 1'b0;
  logic [15:0]   idivider = 16'd16;
  logic          irx = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          oframe_err, ooverrun, otimeout, obusy;

  sv_uart_rx_word #(.DATA_WIDTH(DW), .RX_PIPE(RXP), .TIMEOUT_BITS(20)) dut (
    .iclk(iclk), .irst_n(irst_n), .idivider(idivider), .irx(irx),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .oframe_err(oframe_err), .ooverrun(ooverrun), .otimeout(otimeout), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] beats[$];
  int n_ferr = 0, n_ovr = 0, n_to = 0, to_cyc = 0, rise_cyc = 0, run = 0, last_run = 0;
  bit prev_v = 0, busy_seen = 0;
  int start_cyc = 0;

  // Observe outputs mid-cycle; a beat is taken where tvalid && tready is seen.
  always @(negedge iclk) begin
    #1;
    if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
    if (oframe_err) n_ferr++;
    if (ooverrun) n_ovr++;
    if (otimeout) begin n_to++; to_cyc = cyc; end
    if (obusy) busy_seen = 1;
    if (m_axis_tvalid) begin
      if (!prev_v) rise_cyc = cyc;
      run++;
    end else begin
      if (prev_v) last_run = run;
      run = 0;
    end
    prev_v = m_axis_tvalid;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(negedge iclk);
  endtask

  function automatic int eff(input logic [15:0] d);
    return (d < 16'd4) ? 4 : int'(d);
  endfunction

  // Clocks from driving a start bit to the clock where the sample of `bits`
  // bit-times later has been registered.
  function automatic int lat(input int e, input int bits);
    return RXP + 1 + (e >> 1) + bits * e;
  endfunction

  task automatic clear_mon();
    beats.delete();
    n_ferr = 0; n_ovr = 0; n_to = 0; busy_seen = 0; last_run = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [15:0] d, input bit stop_hi);
    int e;
    e = eff(d);
    idivider = d;
    irx = 1'b0;
    start_cyc = cyc;
    clk(e);
    for (int i = 0; i < 8; i++) begin
      irx = b[i];
      clk(e);
    end
    irx = stop_hi;
    clk(e);
    irx = 1'b1;
  endtask

  typedef struct {
    logic [15:0] div;
    logic [23:0] bytes;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[6];
  logic [7:0]  part[$];
  logic [23:0] expq[$];

  initial begin
    vecs[0] = '{16'd16, 24'hA53C0F, 24'hA53C0F};
    vecs[1] = '{16'd16, 24'h00FF80, 24'h00FF80};
    vecs[2] = '{16'd7,  24'h123456, 24'h123456};
    vecs[3] = '{16'd2,  24'hDEAD01, 24'hDEAD01};
    vecs[4] = '{16'd4,  24'h7E8142, 24'h7E8142};
    vecs[5] = '{16'd33, 24'hC30096, 24'hC30096};

    #1;
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    chk("reset_flags", {oframe_err, ooverrun, otimeout, obusy}, 0);
    clk(3);
    irst_n = 1'b1;
    clk(4);

    // Clean back-to-back words; tvalid must be a single-clock beat after the last stop sample.
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      for (int j = 0; j < 3; j++) send_byte(vecs[v].bytes[23-8*j -: 8], vecs[v].div, 1'b1);
      clk(3 * eff(vecs[v].div));
      chk($sformatf("vec%0d_beats", v), beats.size(), 1);
      chk($sformatf("vec%0d_tdata", v), beats[0], vecs[v].exp);
      chk($sformatf("vec%0d_run", v), last_run, 1);
      chk($sformatf("vec%0d_latency", v), rise_cyc - start_cyc, lat(eff(vecs[v].div), 9));
      chk($sformatf("vec%0d_flags", v), n_ferr + n_ovr + n_to, 0);
    end

    // Short low glitch: false start, back to idle with nothing reported.
    clear_mon();
    idivider = 16'd16;
    irx = 1'b0; clk(5); irx = 1'b1; clk(40);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_after", obusy, 0);
    chk("glitch_beats", beats.size(), 0);
    chk("glitch_flags", n_ferr + n_ovr + n_to, 0);

    // Framing error discards the partial word; the next word is clean.
    clear_mon();
    send_byte(8'h11, 16'd16, 1'b1);
    send_byte(8'h22, 16'd16, 1'b0);
    clk(16);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_obusy", obusy, 0);
    send_byte(8'h33, 16'd16, 1'b1);
    send_byte(8'h44, 16'd16, 1'b1);
    send_byte(8'h55, 16'd16, 1'b1);
    clk(40);
    chk("ferr_beats", beats.size(), 1);
    chk("ferr_tdata", beats[0], 24'h334455);

    // Inter-byte timeout after 20 bit-times of idle.
    clear_mon();
    send_byte(8'h01, 16'd16, 1'b1);
    clk(340);
    chk("to_count", n_to, 1);
    chk("to_time", to_cyc - start_cyc, lat(16, 9) + 20 * 16);
    chk("to_obusy", obusy, 0);
    send_byte(8'h02, 16'd16, 1'b1);
    send_byte(8'h03, 16'd16, 1'b1);
    send_byte(8'h04, 16'd16, 1'b1);
    clk(40);
    chk("to_beats", beats.size(), 1);
    chk("to_tdata", beats[0], 24'h020304);
    chk("to_no_extra", n_to, 1);

    // Overrun: output held while the consumer stalls.
    clear_mon();
    m_axis_tready = 1'b0;
    for (int j = 0; j < 3; j++) send_byte(8'hAA, 16'd8, 1'b1);
    for (int j = 0; j < 3; j++) send_byte(8'h55, 16'd8, 1'b1);
    clk(20);
    chk("ovr_count", n_ovr, 1);
    chk("ovr_tvalid", m_axis_tvalid, 1);
    chk("ovr_tdata", m_axis_tdata, 24'hAAAAAA);
    m_axis_tready = 1'b1;
    clk(4);
    chk("ovr_beats", beats.size(), 1);
    chk("ovr_beat_data", beats[0], 24'hAAAAAA);
    chk("ovr_tvalid_drop", m_axis_tvalid, 0);

    // Reset mid-byte at divider 2 (runs at 4): pending word and frame discarded.
    clear_mon();
    m_axis_tready = 1'b0;
    send_byte(8'h0A, 16'd2, 1'b1);
    send_byte(8'h0B, 16'd2, 1'b1);
    send_byte(8'h0C, 16'd2, 1'b1);
    clk(8);
    chk("rst_pending_tvalid", m_axis_tvalid, 1);
    chk("rst_pending_tdata", m_axis_tdata, 24'h0A0B0C);
    irx = 1'b0; clk(4);
    for (int i = 0; i < 4; i++) begin irx = i[0]; clk(4); end
    irx = 1'b1; clk(2);
    irst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", m_axis_tvalid, 0);
    chk("rst_mid_tdata", m_axis_tdata, 0);
    chk("rst_mid_flags", {oframe_err, ooverrun, otimeout, obusy}, 0);
    clk(3);
    irst_n = 1'b1;
    m_axis_tready = 1'b1;
    clk(6);
    clear_mon();
    send_byte(8'h13, 16'd2, 1'b1);
    send_byte(8'h57, 16'd2, 1'b1);
    send_byte(8'h9B, 16'd2, 1'b1);
    clk(12);
    chk("rst_after_beats", beats.size(), 1);
    chk("rst_after_tdata", beats[0], 24'h13579B);
    chk("rst_after_flags", n_ferr + n_ovr + n_to, 0);

    // Random byte stream against a byte-queue model of word assembly.
    begin
      int exp_ferr, last_e;
      logic [7:0] b;
      logic [15:0] d;
      bit ok;
      clear_mon();
      part.delete();
      expq.delete();
      exp_ferr = 0;
      last_e = 4;
      for (int n = 0; n < 45; n++) begin
        b = 8'($urandom);
        d = 16'($urandom_range(1, 12));
        ok = ($urandom_range(0, 7) != 0);
        last_e = eff(d);
        send_byte(b, d, ok);
        if (!ok) begin
          part.delete();
          exp_ferr++;
          clk(last_e);
        end else begin
          part.push_back(b);
          if (part.size() == 3) begin
            expq.push_back({part[0], part[1], part[2]});
            part.delete();
          end
        end
        clk($urandom_range(0, last_e));
      end
      clk(20 * last_e + 40);
      chk("rnd_beats", beats.size(), expq.size());
      for (int k = 0; k < expq.size(); k++)
        if (k < beats.size()) chk($sformatf("rnd_word%0d", k), beats[k], expq[k]);
      chk("rnd_ferr", n_ferr, exp_ferr);
      chk("rnd_timeout", n_to, (part.size() != 0) ? 1 : 0);
      chk("rnd_ovr", n_ovr, 0);
      chk("rnd_idle", obusy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
